// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helpers used by the strobe FIFO, its interface and the bench.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Level must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
    function automatic int lvl_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/strobe_fifo_if.sv
// Host-side bus of the strobe FIFO: data, strobes, error clear, status flags and fill level.
// The master drives writes and reads; the slave (the FIFO) answers with data and status.
interface strobe_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0]              din;
    logic                               wr_en;
    logic                               rd_en;
    logic                               err_clr;
    logic [DATA_WIDTH-1:0]              dout;
    logic                               empty;
    logic                               full;
    logic                               almost_empty;
    logic                               almost_full;
    logic [lvl_width(ADDR_WIDTH)-1:0]   level;
    logic                               overflow;
    logic                               underflow;

    modport master (
        output din, wr_en, rd_en, err_clr,
        input  dout, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en, err_clr,
        output dout, empty, full, almost_empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/strobe_rise.sv
// Strobe qualifier: rising-edge detect on a held host strobe, or pass-through when EDGE_EN=0.
// Zero latency from en_i to stb_o; no backpressure, the caller decides whether the strobe is accepted.
module strobe_rise #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic stb_o
);
    logic en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= en_i;
    end

    assign stb_o = EDGE_EN ? (en_i & ~en_q) : en_i;
endmodule

// File: rtl/strobe_fifo.sv
// Synchronous FIFO with edge/level strobes, optional FWFT, threshold flags and sticky errors.
// Read data 1 cycle after an accepted read (FWFT=0) or combinational head (FWFT=1); writes when full and reads when empty are dropped and flagged.
module strobe_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit EDGE_EN    = 1'b1,
    parameter bit FWFT       = 1'b0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    strobe_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = lvl_width(ADDR_WIDTH);

    logic                  wr_stb, rd_stb;
    logic                  wr_acc, rd_acc;
    logic                  empty, full;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    strobe_rise #(.EDGE_EN(EDGE_EN)) u_wr_rise (
        .clk   (clk),
        .rst   (rst),
        .en_i  (bus.wr_en),
        .stb_o (wr_stb)
    );

    strobe_rise #(.EDGE_EN(EDGE_EN)) u_rd_rise (
        .clk   (clk),
        .rst   (rst),
        .en_i  (bus.rd_en),
        .stb_o (rd_stb)
    );

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    always_comb begin
        wr_acc   = wr_stb & ~full;
        rd_acc   = rd_stb & ~empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A new error event outranks a clear arriving in the same cycle.
        ovf_d  = (wr_stb & full)  | (ovf_q & ~bus.err_clr);
        unf_d  = (rd_stb & empty) | (unf_q & ~bus.err_clr);
        dout_d = rd_acc ? mem[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.din;
    end

    assign bus.dout         = FWFT ? mem[rd_ptr_q] : dout_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (level_q <= LVL_W'(AE_THRESH));
    assign bus.almost_full  = (level_q >= LVL_W'(AF_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
